// File: rtl/linebuffer_pingpong.sv
// Double-buffered scanline store: draw side fills the back bank, display side reads the front bank.
// Define LINEBUFFER_PINGPONG_CLEAR_ON_READ_EN to zero each front-bank word as it is read.
module linebuffer_pingpong #(
    parameter int WORDS        = 128,
    parameter int PIX_PER_WORD = 16,
    parameter int PIX_W        = 8,
    localparam int AW = $clog2(WORDS),
    localparam int DW = PIX_PER_WORD * PIX_W
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    swap,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [DW-1:0]           rd_data,
    output logic                    rd_valid,
    input  logic [AW-1:0]           wr_addr,
    input  logic [PIX_PER_WORD-1:0] wr_be,
    input  logic [DW-1:0]           wr_data,
    output logic                    front_bank
);

    localparam logic [AW:0] WORDS_C = (AW+1)'(WORDS);

    logic [DW-1:0] mem [2][WORDS];

    logic rd_in_range;
    logic wr_in_range;
    logic draw_go;
    logic clr_go;

    logic                    bank_we    [2];
    logic [AW-1:0]           bank_addr  [2];
    logic [PIX_PER_WORD-1:0] bank_be    [2];
    logic [DW-1:0]           bank_wdata [2];

    assign rd_in_range = ({1'b0, rd_addr} < WORDS_C);
    assign wr_in_range = ({1'b0, wr_addr} < WORDS_C);
    assign draw_go     = rst_pix_n & (|wr_be) & wr_in_range;

`ifdef LINEBUFFER_PINGPONG_CLEAR_ON_READ_EN
    assign clr_go = rst_pix_n & rd_en & rd_in_range;
`else
    assign clr_go = 1'b0;
`endif

    // Each bank has a single write port: the front bank takes the clear, the back bank takes draw.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b]    = 1'b0;
            bank_addr[b]  = wr_addr;
            bank_be[b]    = wr_be;
            bank_wdata[b] = wr_data;
            if (front_bank == b[0]) begin
                bank_we[b]    = clr_go;
                bank_addr[b]  = rd_addr;
                bank_be[b]    = '1;
                bank_wdata[b] = '0;
            end else begin
                bank_we[b]    = draw_go;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        for (int b = 0; b < 2; b++) begin
            if (bank_we[b]) begin
                for (int i = 0; i < PIX_PER_WORD; i++) begin
                    if (bank_be[b][i]) begin
                        mem[b][bank_addr[b]][i*PIX_W +: PIX_W] <= bank_wdata[b][i*PIX_W +: PIX_W];
                    end
                end
            end
        end
    end

    // Read samples the pre-toggle front bank and the pre-clear contents.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            front_bank <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (swap) begin
                front_bank <= ~front_bank;
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range ? mem[front_bank][rd_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_linebuffer_pingpong.sv
// Directed bench for linebuffer_pingpong with WORDS=100 so out-of-range addresses are reachable.
module tb_linebuffer_pingpong;

    localparam int WORDS = 100;
    localparam int PPW   = 16;
    localparam int PW    = 8;
    localparam int AW    = $clog2(WORDS);
    localparam int DW    = PPW * PW;

`ifdef LINEBUFFER_PINGPONG_CLEAR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic           clk_pix;
    logic           rst_pix_n;
    logic           swap;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
    logic           rd_valid;
    logic [AW-1:0]  wr_addr;
    logic [PPW-1:0] wr_be;
    logic [DW-1:0]  wr_data;
    logic           front_bank;

    int checks = 0;
    int errors = 0;

    localparam logic [DW-1:0] P_RAMP  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [DW-1:0] P_AA    = {16{8'hAA}};
    localparam logic [DW-1:0] P_PART  = {{15{8'h77}}, 8'h55};
    localparam logic [DW-1:0] P_AA55  = {{15{8'hAA}}, 8'h55};
    localparam logic [DW-1:0] P_11    = {16{8'h11}};
    localparam logic [DW-1:0] P_22    = {16{8'h22}};
    localparam logic [DW-1:0] P_33    = {16{8'h33}};
    localparam logic [DW-1:0] P_Z0    = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [DW-1:0] P_Z99   = {4{32'hCAFEF00D}};
    localparam logic [DW-1:0] P_FF    = {16{8'hFF}};

    linebuffer_pingpong #(.WORDS(WORDS), .PIX_PER_WORD(PPW), .PIX_W(PW)) dut (
        .clk_pix    (clk_pix),
        .rst_pix_n  (rst_pix_n),
        .swap       (swap),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_addr    (wr_addr),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .front_bank (front_bank)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic idle();
        swap  = 1'b0;
        rd_en = 1'b0;
        wr_be = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [PPW-1:0] be, input logic [DW-1:0] d);
        wr_addr = a;
        wr_be   = be;
        wr_data = d;
        step();
        wr_be   = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        step();
        swap = 1'b0;
    endtask

    initial begin
        rst_pix_n = 1'b0;
        swap      = 1'b1;
        rd_en     = 1'b1;
        rd_addr   = '0;
        wr_addr   = '0;
        wr_be     = '0;
        wr_data   = '0;
        step();
        step();
        check("rst_front", DW'(front_bank), DW'(0));
        check("rst_valid", DW'(rd_valid), DW'(0));
        check("rst_data", rd_data, '0);

        rst_pix_n = 1'b1;
        idle();
        step();

        // Preload bank 0 addr 7 while it is the back bank.
        do_swap();
        check("swap_toggle", DW'(front_bank), DW'(1));
        wr(7, '1, P_33);
        do_swap();
        check("swap_back", DW'(front_bank), DW'(0));

        // Draw into bank 1.
        wr(5, '1, P_RAMP);
        wr(3, '1, P_AA);
        wr(3, 16'h0001, P_PART);
        wr(7, '1, P_22);
        wr(0, '1, P_Z0);
        wr(99, '1, P_Z99);
        wr(7'd120, '1, P_FF);

        // Swap, write and read all in one cycle.
        swap    = 1'b1;
        wr_addr = 7;
        wr_be   = '1;
        wr_data = P_11;
        rd_en   = 1'b1;
        rd_addr = 7;
        step();
        idle();
        check("swap_rd_old_front", rd_data, P_33);
        check("swap_rd_valid", DW'(rd_valid), DW'(1));
        check("swap_new_front", DW'(front_bank), DW'(1));
        step();
        check("valid_drop", DW'(rd_valid), DW'(0));
        check("rd_hold", rd_data, P_33);

        rd_en   = 1'b1;
        rd_addr = 5;
        step();
        check("rd_ramp", rd_data, P_RAMP);
        check("rd_ramp_valid", DW'(rd_valid), DW'(1));
        step();
        rd_en = 1'b0;
        check("rd_ramp_again", rd_data, CLR ? '0 : P_RAMP);

        rd(3);
        check("rd_partial", rd_data, P_AA55);
        rd(7);
        check("swap_wr_new_front", rd_data, P_11);
        rd(7'd120);
        check("rd_oob_data", rd_data, '0);
        check("rd_oob_valid", DW'(rd_valid), DW'(1));
        rd(0);
        check("rd_addr0", rd_data, P_Z0);
        rd(99);
        check("rd_addr99", rd_data, P_Z99);
        step();
        check("valid_idle", DW'(rd_valid), DW'(0));

        do_swap();
        check("front_after_swap", DW'(front_bank), DW'(0));
        rd(7);
        check("old_back_unchanged", rd_data, CLR ? '0 : P_33);

        // Reset mid-line with a read in flight.
        do_swap();
        rst_pix_n = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = 0;
        step();
        rst_pix_n = 1'b1;
        idle();
        check("midrst_front", DW'(front_bank), DW'(0));
        check("midrst_valid", DW'(rd_valid), DW'(0));
        check("midrst_data", rd_data, '0);
        do_swap();
        rd(3);
        check("post_rst_contents", rd_data, CLR ? '0 : P_AA55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
